mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the data word width.
REQ-002 Parameter ADDR_W, default 10, SHALL set the RAM word-address width.
REQ-003 clk  input  1  SHALL be the clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req[2:0]  input  3  SHALL carry the level requests: bit0 data (load/store), bit1 fetch, bit2 io.
REQ-006 we[2:0]  input  3  SHALL give the per-requester write qualifier (1 write, 0 read).
REQ-007 addr0/addr1/addr2  input  ADDR_W each  SHALL give the per-requester word address.
REQ-008 wdata0/wdata1/wdata2  input  DATA_W each  SHALL give the per-requester write data.
REQ-009 ack[2:0]  output  3  SHALL carry the one-cycle completion pulse per requester.
REQ-010 rdata  output  DATA_W  SHALL carry the read data, valid while the matching ack bit is high.
REQ-011 gnt_id  output  2  SHALL give the index of the current or last granted requester.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.
REQ-013 ram_addr  output  ADDR_W  SHALL drive the single-port RAM address.
REQ-014 ram_din  output  DATA_W  SHALL drive the RAM write data.
REQ-015 ram_we  output  1  SHALL drive the RAM write enable.
REQ-016 ram_dout  input  DATA_W  SHALL carry the RAM read data, one-cycle synchronous read latency.

Function
REQ-017 The FSM SHALL have four states, IDLE, ACCESS, RESP and ACK, with no other reachable state.
REQ-018 IDLE: if any req bit is high at a rising edge, the block SHALL pick a winner and latch its we, addr and wdata, then go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: the search order SHALL be ptr+1, ptr+2, ptr (mod 3), where ptr is the last granted index.
REQ-020 ACCESS: ram_addr, ram_din and ram_we SHALL come from the latched values for exactly one cycle; the next state SHALL be RESP.
REQ-021 ram_we SHALL be 0 in every state except ACCESS, so there is exactly one write strobe per granted write.
REQ-022 RESP: for a read, rdata SHALL be loaded from ram_dout at the end of the cycle; for a write, rdata SHALL hold its value. The next state SHALL be ACK.
REQ-023 ACK: ack[gnt_id] SHALL be 1 for exactly one cycle and ptr SHALL update to gnt_id. No arbitration SHALL occur in ACK; the next state SHALL be IDLE.
REQ-024 Latency: from the edge that samples req in IDLE to the cycle in which ack is high SHALL be 3 cycles; throughput SHALL be at most one access per 4 cycles.
REQ-025 At most one ack bit SHALL be high in any cycle.
REQ-026 A req that drops after it is latched SHALL NOT abort the transaction; it SHALL still complete and be acked.
REQ-027 A req still high in IDLE after its ack SHALL be treated as a new transaction and arbitrated normally.
REQ-028 When all three req bits are held high, grants SHALL rotate 0,1,2,0,… with no requester waiting more than two other grants.
REQ-029 Changes to we, addr or wdata while busy SHALL have no effect on the transaction in flight.
REQ-030 Address arithmetic SHALL NOT be applied: addresses SHALL pass through unmodified, ADDR_W bits, with no wrap logic.

Reset
REQ-031 When reset is 0, the block SHALL immediately set state=IDLE, ack=0, ram_we=0, busy=0, rdata=0, ram_addr=0, ram_din=0, gnt_id=0 and ptr=2, so requester 0 has first priority.
REQ-032 Reset mid-transaction SHALL abandon it with no ack; a write SHALL have taken effect only if ACCESS had already completed.
REQ-033 The first arbitration SHALL occur at the first rising edge after reset returns to 1.

Structure
REQ-034 The shared package cpu_pkg SHALL hold the state encoding (IDLE=0, ACCESS=1, RESP=2, ACK=3) and the requester IDs REQ_DATA=0, REQ_FETCH=1, REQ_IO=2.
REQ-035 Winner selection SHALL be a combinational sub-module rr_pick3 (inputs req[2:0] and ptr[1:0]; outputs valid and idx[1:0]), instantiated once.

Verification
REQ-036 Idle: reset, then req=0 for 10 cycles -> busy=0, ram_we=0, ack=0 throughout.
REQ-037 Write then read: requester 1 writes 0xBEEF to addr 0x05 (ack seen), then reads addr 0x05 -> ram_we high in exactly one cycle; ack[1] three cycles after each sample; rdata=0xBEEF.
REQ-038 Contention: req=3'b111 held, each requester reads a distinct preloaded address -> ack order 0,1,2,0,1,2 with 4-cycle spacing and the correct rdata each time.
REQ-039 Early drop: requester 2 asserts req for one cycle only, reading addr 0x3FF holding 0x1234 -> ack[2] still pulses and rdata=0x1234.
REQ-040 Mid-write reset: reset asserted during RESP of a write -> outputs return to reset values at once and no ack is seen; after release a read of the written address returns the new data, and a reset during ACCESS leaves the old data.
REQ-041 Rotation: after a grant to requester 0, assert req=3'b101 -> requester 2 is granted before requester 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, requester IDs and
// the modulo-3 pointer arithmetic used by the round-robin picker.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ACK    = 2'd3
  } state_t;

  localparam logic [1:0] REQ_DATA  = 2'd0;
  localparam logic [1:0] REQ_FETCH = 2'd1;
  localparam logic [1:0] REQ_IO    = 2'd2;

  // Last-granted pointer starts on IO so that the data port is searched first.
  localparam logic [1:0] PTR_RST = REQ_IO;

  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd6) begin
      s = s - 3'd6;
    end else if (s >= 3'd3) begin
      s = s - 3'd3;
    end
    return s[1:0];
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick3.sv
// Combinational round-robin winner select over three requesters.
// Search order is ptr+1, ptr+2, ptr (mod 3); zero latency, no backpressure.
module rr_pick3
  import cpu_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] w_c1;
  logic [1:0] w_c2;
  logic [1:0] w_c3;

  assign w_c1  = mod3_add(ptr, 2'd1);
  assign w_c2  = mod3_add(ptr, 2'd2);
  assign w_c3  = mod3_add(ptr, 2'd0);
  assign valid = |req;

  always_comb begin
    idx = w_c3;
    if (req[w_c1]) begin
      idx = w_c1;
    end else if (req[w_c2]) begin
      idx = w_c2;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-way round-robin arbiter in front of a single-port synchronous RAM.
// Ack arrives 3 cycles after the sampling edge; one access per 4 cycles, losers simply keep req high.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        gnt_id,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t              r_state;
  logic [1:0]          r_ptr;
  logic [1:0]          r_gnt;
  logic                r_we;
  logic [2:0]          r_ack;
  logic                r_busy;
  logic [DATA_W-1:0]   r_rdata;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_din;
  logic                r_ram_we;

  logic                w_valid;
  logic [1:0]          w_idx;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  rr_pick3 u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .valid (w_valid),
    .idx   (w_idx)
  );

  always_comb begin
    w_sel_we    = we[0];
    w_sel_addr  = addr0;
    w_sel_wdata = wdata0;
    case (w_idx)
      REQ_DATA: begin
        w_sel_we    = we[0];
        w_sel_addr  = addr0;
        w_sel_wdata = wdata0;
      end
      REQ_FETCH: begin
        w_sel_we    = we[1];
        w_sel_addr  = addr1;
        w_sel_wdata = wdata1;
      end
      REQ_IO: begin
        w_sel_we    = we[2];
        w_sel_addr  = addr2;
        w_sel_wdata = wdata2;
      end
      default: ;
    endcase
  end

  // The RAM address/data registers double as the latched request, so
  // requester inputs are ignored for the rest of the transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_ptr      <= PTR_RST;
      r_gnt      <= 2'd0;
      r_we       <= 1'b0;
      r_ack      <= 3'b000;
      r_busy     <= 1'b0;
      r_rdata    <= '0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ram_we   <= 1'b0;
    end else begin
      r_ack    <= 3'b000;
      r_ram_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_gnt      <= w_idx;
            r_we       <= w_sel_we;
            r_ram_addr <= w_sel_addr;
            r_ram_din  <= w_sel_wdata;
            r_ram_we   <= w_sel_we;
            r_busy     <= 1'b1;
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          r_state <= RESP;
        end
        RESP: begin
          if (!r_we) begin
            r_rdata <= ram_dout;
          end
          r_ack   <= 3'b001 << r_gnt;
          r_state <= ACK;
        end
        ACK: begin
          r_ptr   <= r_gnt;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign rdata    = r_rdata;
  assign gnt_id   = r_gnt;
  assign busy     = r_busy;
  assign ram_addr = r_ram_addr;
  assign ram_din  = r_ram_din;
  assign ram_we   = r_ram_we;

endmodule
